cla_pipe_addsub: RTL

Parametrised, pipelined carry-lookahead adder/subtractor for the InOrderSingleIssue arithmetic unit. Operands are split into STAGE_BITS-wide slices. Each pipeline stage resolves one slice with 4-bit lookahead groups and registers the carry into the next stage. It sits between operand select and writeback, uses a valid/ready handshake on both sides, and provides carry-out, signed overflow and optional saturation.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/cla_group4.sv | 37 +++
 rtl/cla_pipe_addsub.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared arithmetic-unit types for the InOrderSingleIssue pipeline: the lookahead
// carry primitive and the per-stage register record used by cla_pipe_addsub.
package rv32_pkg;

    localparam int CLA_GROUP_W = 4;
    // Widest operand a stage record can carry; narrower builds leave the top bits zero.
    localparam int CLA_MAX_W   = 64;

    typedef struct packed {
        logic                 valid;
        logic                 sat;
        logic                 carry;
        logic [CLA_MAX_W-1:0] a;
        logic [CLA_MAX_W-1:0] b;
        logic [CLA_MAX_W-1:0] sum;
    } cla_stage_t;

    function automatic logic cla_bit(input logic g, input logic p, input logic c);
        return g | (p & c);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: sum, group generate/propagate and carry-out.
module cla_group4
    import rv32_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] a,
    input  logic [CLA_GROUP_W-1:0] b,
    input  logic                   cin,
    output logic [CLA_GROUP_W-1:0] sum,
    output logic                   g,
    output logic                   p,
    output logic                   cout
);

    logic [CLA_GROUP_W-1:0] bg;
    logic [CLA_GROUP_W-1:0] bp;
    logic [CLA_GROUP_W:0]   c;

    assign bg = a & b;
    assign bp = a ^ b;

    // Each internal carry is a flat sum of products of cin and the bit terms.
    assign c[0] = cin;
    assign c[1] = cla_bit(bg[0], bp[0], cin);
    assign c[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
    assign c[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                | (bp[2] & bp[1] & bp[0] & cin);

    assign g = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
             | (bp[3] & bp[2] & bp[1] & bg[0]);
    assign p = &bp;

    assign c[4] = cla_bit(g, p, cin);

    assign sum  = bp ^ c[CLA_GROUP_W-1:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one STAGE_BITS slice resolved per stage.
// Signed saturation on request is built only when CLA_ADDSUB_SAT_EN is defined.
module cla_pipe_addsub
    import rv32_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STAGE_BITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTAGES = WIDTH / STAGE_BITS;
    localparam int NGROUPS = STAGE_BITS / CLA_GROUP_W;

    // Handshake: a transfer occurs on a rising edge where valid and ready are both 1.
    // All stage registers advance together on adv, so a blocked output freezes the pipe.
    logic       adv;
    cla_stage_t front;
    cla_stage_t fin_d;
    logic       ovf_d;
    logic       ovf_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        front       = '0;
        front.valid = in_valid;
        front.a     = CLA_MAX_W'(a);
        front.b     = CLA_MAX_W'(b ^ {WIDTH{sub}});
        front.carry = sub | cin;
`ifdef CLA_ADDSUB_SAT_EN
        front.sat   = sat;
`endif
    end

`ifndef CLA_ADDSUB_SAT_EN
    logic unused_sat;
    assign unused_sat = sat;
`endif

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        cla_stage_t            cur;
        cla_stage_t            nx;
        cla_stage_t            d;
        cla_stage_t            q;
        logic [NGROUPS:0]      gc;
        logic [NGROUPS-1:0]    unused_g;
        logic [NGROUPS-1:0]    unused_p;
        logic [STAGE_BITS-1:0] ss;

        if (k == 0) begin : g_first
            assign cur = front;
        end else begin : g_next
            assign cur = g_stage[k-1].q;
        end

        assign gc[0] = cur.carry;

        for (genvar j = 0; j < NGROUPS; j++) begin : g_grp
            cla_group4 u_grp (
                .a    (cur.a[k*STAGE_BITS + j*CLA_GROUP_W +: CLA_GROUP_W]),
                .b    (cur.b[k*STAGE_BITS + j*CLA_GROUP_W +: CLA_GROUP_W]),
                .cin  (gc[j]),
                .sum  (ss[j*CLA_GROUP_W +: CLA_GROUP_W]),
                .g    (unused_g[j]),
                .p    (unused_p[j]),
                .cout (gc[j+1])
            );
        end

        always_comb begin
            nx                                  = cur;
            nx.sum[k*STAGE_BITS +: STAGE_BITS]  = ss;
            nx.carry                            = gc[NGROUPS];
        end

        // The last stage registers the flag/saturation result so every output is a flop.
        if (k == NSTAGES - 1) begin : g_tail
            logic unused_tail;
            assign d           = fin_d;
            assign unused_tail = ^q;
        end else begin : g_body
            assign d = nx;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q <= '0;
            end else if (adv) begin
                q <= d;
            end
        end
    end

`ifdef CLA_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    always_comb begin
        fin_d = g_stage[NSTAGES-1].nx;
        ovf_d = (fin_d.a[WIDTH-1] == fin_d.b[WIDTH-1])
              & (fin_d.sum[WIDTH-1] != fin_d.a[WIDTH-1]);
`ifdef CLA_ADDSUB_SAT_EN
        if (fin_d.sat && ovf_d) begin
            fin_d.sum = fin_d.a[WIDTH-1] ? CLA_MAX_W'(SAT_MIN) : CLA_MAX_W'(SAT_MAX);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = g_stage[NSTAGES-1].q.valid;
    assign sum       = g_stage[NSTAGES-1].q.sum[WIDTH-1:0];
    assign cout      = g_stage[NSTAGES-1].q.carry;
    assign ovf       = ovf_q;

endmodule
